avst_hex_encoder: RTL and testbench
===================================

AVST_HEX_ENCODER -- requirements
Module: avst_hex_encoder

Interface
REQ-001 Parameter EMIT_NL, default 1: when 1, a newline character (0x0A) closes every packet.
REQ-002 Parameter LOWERCASE, default 0: when 1, hex digits a-f are lowercase (0x61-0x66); when 0, A-F are uppercase (0x41-0x46).
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 data_in  input  8  binary byte from the upstream adder_avst result stream.
REQ-006 end_in  input  1  marks the last byte of an input packet.
REQ-007 valid_in  input  1  data_in/end_in are valid.
REQ-008 ready_in  output  1  block accepts a byte this cycle.
REQ-009 data_out  output  8  ASCII character.
REQ-010 end_out  output  1  marks the last character of an output packet.
REQ-011 valid_out  output  1  data_out/end_out are valid.
REQ-012 ready_out  input  1  downstream sink accepts a character this cycle.

Function
REQ-013 Input transfer when valid_in=1 and ready_in=1 at a rising edge; output transfer when valid_out=1 and ready_out=1 at a rising edge.
REQ-014 Each accepted byte produces two characters: high nibble first, then low nibble; nibble 0-9 maps to 0x30-0x39, nibble 10-15 maps per LOWERCASE.
REQ-015 FSM states: IDLE (no byte held), HI (high char presented), LO (low char presented), NL (newline presented).
REQ-016 IDLE -> HI on input transfer; byte and end_in are captured into a holding register on the same edge.
REQ-017 HI -> LO on output transfer; HI holds otherwise.
REQ-018 LO on output transfer: if held end=1 and EMIT_NL=1, go to NL; otherwise go to HI if an input transfer occurs on the same edge, else go to IDLE.
REQ-019 NL on output transfer: go to HI if an input transfer occurs on the same edge, else go to IDLE.
REQ-020 ready_in = (state==IDLE) | (state==LO & ready_out & !(held_end & EMIT_NL)) | (state==NL & ready_out); ready_in is 0 while reset=1.
REQ-021 valid_out = 1 exactly in states HI, LO and NL. The output is registered: it is never combinationally driven from data_in or valid_in.
REQ-022 Latency: a byte accepted at edge N presents its high char in the cycle after edge N.
REQ-023 Sustained throughput with ready_out=1: one byte per 2 cycles, or per 3 cycles for a packet-end byte with EMIT_NL=1. No bubbles between back-to-back bytes.
REQ-024 end_out = 1 only on the final character of a packet: the NL character if EMIT_NL=1, else the LO character of a byte with end_in=1. end_out = 0 on all other characters.
REQ-025 While valid_out=1 and ready_out=0, data_out, end_out and valid_out hold stable, and no new byte is accepted unless REQ-020 permits it.
REQ-026 In IDLE, data_out and end_out hold their last values; sinks ignore them while valid_out=0.
REQ-027 A byte with end_in=1 arriving alone (a single-byte packet) encodes normally. end_in is sampled only on an input transfer.
REQ-028 valid_in asserted while ready_in=0 is not consumed; the source holds it (AVST rules).

Reset
REQ-029 While reset=1 at a rising edge: state goes to IDLE, the holding register clears to 0, valid_out=0, data_out=0x00, end_out=0, and ready_in=0.
REQ-030 Reset mid-byte or mid-packet discards the held byte and any pending characters. No partial character is emitted after reset deasserts.
REQ-031 ready_in = 1 in the first cycle after reset deasserts.

Verification
REQ-032 Byte 0x3A, end_in=0, ready_out=1 -> characters 0x33, 0x41 on consecutive cycles, end_out=0, first character one cycle after acceptance.
REQ-033 Byte 0xF0, end_in=1, EMIT_NL=1 -> characters 0x46, 0x30, 0x0A, with end_out=1 on 0x0A only; with EMIT_NL=0 -> 0x46, 0x30(end_out=1).
REQ-034 Bytes 0x12, 0x34 with valid_in held high and ready_out=1 -> characters 0x31, 0x32, 0x33, 0x34 on four consecutive cycles; ready_in pulses on the LO cycles.
REQ-035 Byte 0xC5 with ready_out=0 for 3 cycles during LO -> 0x35 held stable with valid_out=1, ready_in=0; the character transfers once on ready_out=1.
REQ-036 Byte 0x7E accepted, then reset=1 for 1 cycle during HI -> valid_out=0, data_out=0x00, no 0x45 ever emitted; the next byte 0x01 yields 0x30, 0x31.
REQ-037 LOWERCASE=1, byte 0xAB -> characters 0x61, 0x62.

Source files
------------

// File: rtl/avst_hex_encoder.sv
// Avalon-ST byte-to-ASCII-hex encoder: two characters per byte, high nibble first,
// with an optional newline closing each packet.
module avst_hex_encoder #(
    parameter logic EMIT_NL   = 1'b1,
    parameter logic LOWERCASE = 1'b0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] data_in,
    input  logic       end_in,
    input  logic       valid_in,
    output logic       ready_in,
    output logic [7:0] data_out,
    output logic       end_out,
    output logic       valid_out,
    input  logic       ready_out
);

    typedef enum logic [1:0] {IDLE, HI, LO, NL} state_t;

    state_t     state, state_nxt;
    logic [7:0] held_data, held_data_nxt;
    logic       held_end, held_end_nxt;
    logic [7:0] data_nxt;
    logic       end_nxt;
    logic       in_xfer, out_xfer, nl_due;

    function automatic logic [7:0] hex_char(input logic [3:0] n);
        if (n < 4'd10)
            hex_char = 8'h30 + {4'h0, n};
        else
            hex_char = (LOWERCASE ? 8'h61 : 8'h41) + {4'h0, n} - 8'd10;
    endfunction

    assign nl_due    = held_end & EMIT_NL;
    assign valid_out = (state != IDLE);
    assign ready_in  = !reset & ((state == IDLE)
                     | (state == LO & ready_out & !nl_due)
                     | (state == NL & ready_out));
    assign in_xfer   = valid_in & ready_in;
    assign out_xfer  = valid_out & ready_out;

    always_comb begin
        state_nxt     = state;
        held_data_nxt = held_data;
        held_end_nxt  = held_end;
        data_nxt      = data_out;
        end_nxt       = end_out;

        unique case (state)
            IDLE: if (in_xfer) state_nxt = HI;
            HI:   if (out_xfer) state_nxt = LO;
            LO:   if (out_xfer) state_nxt = nl_due ? NL : (in_xfer ? HI : IDLE);
            NL:   if (out_xfer) state_nxt = in_xfer ? HI : IDLE;
        endcase

        // A new byte is only ever accepted when the previous one is fully drained,
        // so capture and the high character load share one path.
        if (in_xfer) begin
            held_data_nxt = data_in;
            held_end_nxt  = end_in;
            data_nxt      = hex_char(data_in[7:4]);
            end_nxt       = 1'b0;
        end else if (state == HI && out_xfer) begin
            data_nxt = hex_char(held_data[3:0]);
            end_nxt  = held_end & !EMIT_NL;
        end else if (state == LO && out_xfer && nl_due) begin
            data_nxt = 8'h0A;
            end_nxt  = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            held_data <= 8'h00;
            held_end  <= 1'b0;
            data_out  <= 8'h00;
            end_out   <= 1'b0;
        end else begin
            state     <= state_nxt;
            held_data <= held_data_nxt;
            held_end  <= held_end_nxt;
            data_out  <= data_nxt;
            end_out   <= end_nxt;
        end
    end

endmodule

// File: tb/tb_avst_hex_encoder.sv
// Bench for avst_hex_encoder: three parameterisations checked against a
// character-queue model, plus literal character sequences.
module tb_avst_hex_encoder;

    logic            clk = 1'b0;
    logic            reset;
    logic [2:0][7:0] data_in;
    logic [2:0]      end_in, valid_in, ready_in;
    logic [2:0][7:0] data_out;
    logic [2:0]      end_out, valid_out, ready_out;

    always #5 clk = ~clk;

    avst_hex_encoder #(.EMIT_NL(1'b1), .LOWERCASE(1'b0)) dut0 (
        .clk(clk), .reset(reset), .data_in(data_in[0]), .end_in(end_in[0]),
        .valid_in(valid_in[0]), .ready_in(ready_in[0]), .data_out(data_out[0]),
        .end_out(end_out[0]), .valid_out(valid_out[0]), .ready_out(ready_out[0]));

    avst_hex_encoder #(.EMIT_NL(1'b0), .LOWERCASE(1'b0)) dut1 (
        .clk(clk), .reset(reset), .data_in(data_in[1]), .end_in(end_in[1]),
        .valid_in(valid_in[1]), .ready_in(ready_in[1]), .data_out(data_out[1]),
        .end_out(end_out[1]), .valid_out(valid_out[1]), .ready_out(ready_out[1]));

    avst_hex_encoder #(.EMIT_NL(1'b1), .LOWERCASE(1'b1)) dut2 (
        .clk(clk), .reset(reset), .data_in(data_in[2]), .end_in(end_in[2]),
        .valid_in(valid_in[2]), .ready_in(ready_in[2]), .data_out(data_out[2]),
        .end_out(end_out[2]), .valid_out(valid_out[2]), .ready_out(ready_out[2]));

    // Model: pending characters {end, char} per channel, oldest first.
    bit         emit_nl[3];
    bit         lc[3];
    int         cnt[3];
    logic [8:0] mq[3][4];
    logic [8:0] last[3];
    logic [8:0] logv[3][16];
    int         logn[3];
    bit         acc[3];
    int         errors = 0;
    int         checks = 0;

    task automatic chk(input string nm, input int k, input logic [8:0] got,
                       input logic [8:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s ch%0d: got %h, want %h at %0t", nm, k, got, want, $time);
        end
    endtask

    task automatic push_byte(input int k, input logic [7:0] b, input logic e);
        string      dg;
        logic [7:0] c;
        dg = lc[k] ? "0123456789abcdef" : "0123456789ABCDEF";
        c = dg[int'(b[7:4])];
        mq[k][cnt[k]] = {1'b0, c};
        cnt[k]++;
        c = dg[int'(b[3:0])];
        mq[k][cnt[k]] = {e & !emit_nl[k], c};
        cnt[k]++;
        if (e && emit_nl[k]) begin
            mq[k][cnt[k]] = {1'b1, 8'h0A};
            cnt[k]++;
        end
    endtask

    // Called at a negedge with inputs already set; returns at the next negedge.
    task automatic tick();
        logic xin[3];
        logic xout[3];
        logic exp_rdy;
        #1;
        for (int k = 0; k < 3; k++) begin
            exp_rdy = !reset && (cnt[k] == 0 || (cnt[k] == 1 && ready_out[k]));
            chk("ready_in", k, 9'(ready_in[k]), 9'(exp_rdy));
            chk("valid_out", k, 9'(valid_out[k]), 9'(cnt[k] != 0));
            if (cnt[k] != 0)
                chk("char", k, {end_out[k], data_out[k]}, mq[k][0]);
            else
                chk("idle_hold", k, {end_out[k], data_out[k]}, last[k]);
            xin[k]  = valid_in[k] & exp_rdy;
            xout[k] = (cnt[k] != 0) & ready_out[k];
            acc[k]  = xin[k];
        end
        @(posedge clk);
        for (int k = 0; k < 3; k++) begin
            if (reset) begin
                cnt[k]  = 0;
                last[k] = 9'h000;
            end else begin
                if (xout[k]) begin
                    last[k] = mq[k][0];
                    if (logn[k] < 16) logv[k][logn[k]] = mq[k][0];
                    logn[k]++;
                    for (int i = 0; i < 3; i++) mq[k][i] = mq[k][i+1];
                    cnt[k]--;
                end
                if (xin[k]) push_byte(k, data_in[k], end_in[k]);
            end
        end
        @(negedge clk);
    endtask

    task automatic clear_logs();
        for (int k = 0; k < 3; k++) logn[k] = 0;
    endtask

    task automatic check_log(input string nm, input int k, input int n,
                             input logic [8:0] e0, input logic [8:0] e1,
                             input logic [8:0] e2, input logic [8:0] e3);
        logic [8:0] e[4];
        bit ok;
        e = '{e0, e1, e2, e3};
        ok = (logn[k] == n);
        for (int i = 0; i < 4; i++)
            if (i < n && logv[k][i] !== e[i]) ok = 0;
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s ch%0d: got %0d chars %h %h %h %h, want %0d chars %h %h %h %h",
                     nm, k, logn[k], logv[k][0], logv[k][1], logv[k][2], logv[k][3],
                     n, e0, e1, e2, e3);
        end
    endtask

    task automatic send_bytes(input int n, input logic [7:0] b0, input logic [7:0] b1,
                              input logic e, input int drain);
        int         pos[3];
        logic [7:0] bl[2];
        bit         done;
        int         guard;
        bl = '{b0, b1};
        guard = 0;
        for (int k = 0; k < 3; k++) begin
            pos[k] = 0;
            valid_in[k] = 1'b1;
            data_in[k] = bl[0];
            end_in[k] = e;
            ready_out[k] = 1'b1;
        end
        do begin
            tick();
            done = 1;
            for (int k = 0; k < 3; k++) begin
                if (acc[k] && pos[k] < n) begin
                    pos[k]++;
                    if (pos[k] < n) data_in[k] = bl[pos[k]];
                    else valid_in[k] = 1'b0;
                end
                if (pos[k] < n) done = 0;
            end
            guard++;
        end while (!done && guard < 40);
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: got %0d/%0d/%0d, want %0d accepted",
                     pos[0], pos[1], pos[2], n);
            valid_in = '0;
        end
        repeat (drain) tick();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1);
    end

    initial begin
        emit_nl = '{1, 0, 1};
        lc      = '{0, 0, 1};
        reset     = 1'b1;
        valid_in  = '0;
        data_in   = '0;
        end_in    = '0;
        ready_out = '1;
        for (int k = 0; k < 3; k++) begin
            cnt[k]  = 0;
            last[k] = 9'h000;
            logn[k] = 0;
            acc[k]  = 0;
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        tick();
        reset = 1'b0;

        clear_logs();
        send_bytes(1, 8'h3A, 8'h00, 1'b0, 4);
        check_log("hex_3a", 0, 2, 9'h033, 9'h041, 9'h000, 9'h000);
        check_log("hex_3a", 1, 2, 9'h033, 9'h041, 9'h000, 9'h000);
        check_log("hex_3a", 2, 2, 9'h033, 9'h061, 9'h000, 9'h000);

        clear_logs();
        send_bytes(1, 8'hF0, 8'h00, 1'b1, 5);
        check_log("pkt_f0", 0, 3, 9'h046, 9'h030, 9'h10A, 9'h000);
        check_log("pkt_f0", 1, 2, 9'h046, 9'h130, 9'h000, 9'h000);
        check_log("pkt_f0", 2, 3, 9'h066, 9'h030, 9'h10A, 9'h000);

        clear_logs();
        send_bytes(2, 8'h12, 8'h34, 1'b0, 4);
        for (int k = 0; k < 3; k++)
            check_log("b2b_1234", k, 4, 9'h031, 9'h032, 9'h033, 9'h034);

        clear_logs();
        send_bytes(1, 8'hC5, 8'h00, 1'b0, 0);
        tick();
        ready_out = '0;
        repeat (3) begin
            #1;
            chk("stall_data", 0, {end_out[0], data_out[0]}, 9'h035);
            chk("stall_valid", 0, 9'(valid_out[0]), 9'h001);
            chk("stall_ready_in", 0, 9'(ready_in[0]), 9'h000);
            tick();
        end
        ready_out = '1;
        repeat (4) tick();
        check_log("stall_c5", 0, 2, 9'h043, 9'h035, 9'h000, 9'h000);
        check_log("stall_c5", 2, 2, 9'h063, 9'h035, 9'h000, 9'h000);

        clear_logs();
        send_bytes(1, 8'h7E, 8'h00, 1'b0, 0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        chk("rst_valid", 0, 9'(valid_out[0]), 9'h000);
        chk("rst_data", 0, {end_out[0], data_out[0]}, 9'h000);
        chk("rst_ready_in", 0, 9'(ready_in[0]), 9'h001);
        tick();
        send_bytes(1, 8'h01, 8'h00, 1'b0, 4);
        for (int k = 0; k < 3; k++)
            check_log("rst_then_01", k, 2, 9'h030, 9'h031, 9'h000, 9'h000);

        clear_logs();
        send_bytes(1, 8'hAB, 8'h00, 1'b0, 4);
        check_log("case_ab", 0, 2, 9'h041, 9'h042, 9'h000, 9'h000);
        check_log("case_ab", 2, 2, 9'h061, 9'h062, 9'h000, 9'h000);

        for (int c = 0; c < 1500; c++) begin
            for (int k = 0; k < 3; k++) begin
                if (!valid_in[k] || acc[k]) begin
                    valid_in[k] = ($urandom_range(0, 9) < 6);
                    data_in[k]  = 8'($urandom);
                    end_in[k]   = ($urandom_range(0, 3) == 0);
                end
                ready_out[k] = ($urandom_range(0, 9) < 7);
            end
            reset = ($urandom_range(0, 199) == 0);
            tick();
        end
        reset = 1'b0;
        valid_in = '0;
        ready_out = '1;
        repeat (5) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
